// File: rtl/cpu_pkg.sv
// Shared CPU-wide definitions for register numbering.
package cpu_pkg;

  localparam int REG_NUM_W = 5;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_NUM_W-1:0] reg_num_t;

  localparam reg_num_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback side of the register scoreboard: issue request, issue
// grant, writeback release and pipeline flush.
interface reg_scoreboard_if;
  import cpu_pkg::*;

  logic     issue_valid;
  reg_num_t issue_rs;
  reg_num_t issue_rt;
  logic     issue_use_rt;
  logic     issue_wr;
  reg_num_t issue_rd;
  logic     issue_ready;
  logic     wb_valid;
  reg_num_t wb_num;
  logic     flush;

  // Pipeline side: presents instructions and writebacks, receives the grant.
  modport master (
    output issue_valid, issue_rs, issue_rt, issue_use_rt, issue_wr, issue_rd,
    output wb_valid, wb_num, flush,
    input  issue_ready
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_use_rt, issue_wr, issue_rd,
    input  wb_valid, wb_num, flush,
    output issue_ready
  );

endinterface

// File: rtl/sb_counter.sv
// Pending-write counter for one register. Increments and decrements in the
// same cycle cancel; the count never wraps in either direction.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             is_zero,
  output logic             is_max
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, then a lone inc or dec moves the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;
  assign is_zero = (cnt_q == '0);
  assign is_max  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: holds issue while a source has a pending write (with
// same-cycle writeback bypass) or the destination counter is full. Register 0
// is never tracked.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  reg_scoreboard_if.slave     sb,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [STALL_W-1:0]  stall_cnt,
  output logic                err
);

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic [CNT_W-1:0]    cnt     [NUM_REGS];
  logic [CNT_W-1:0]    cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] is_zero;
  logic [NUM_REGS-1:0] is_max;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;

  logic rs_busy;
  logic rt_busy;
  logic rd_full;
  logic ready;
  logic accepted;

  logic [NUM_REGS-1:0] busy_mask_q, busy_mask_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic                err_q, err_d;

  // Register 0 behaves as a counter pinned at zero.
  assign cnt[0]     = '0;
  assign cnt_nxt[0] = '0;
  assign is_zero[0] = 1'b1;
  assign is_max[0]  = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc[g]),
      .dec     (dec[g]),
      .clr     (sb.flush),
      .cnt     (cnt[g]),
      .cnt_nxt (cnt_nxt[g]),
      .is_zero (is_zero[g]),
      .is_max  (is_max[g])
    );
  end

  // Hazard check. A source whose only pending write retires this cycle is
  // free, since the register file writes on the opposite edge.
  always_comb begin
    rs_busy = !is_zero[sb.issue_rs] &&
              !(sb.wb_valid && (sb.wb_num == sb.issue_rs) && (cnt[sb.issue_rs] == CNT_ONE));
    rt_busy = !is_zero[sb.issue_rt] &&
              !(sb.wb_valid && (sb.wb_num == sb.issue_rt) && (cnt[sb.issue_rt] == CNT_ONE));
    rd_full = sb.issue_wr && (sb.issue_rd != REG_ZERO) && is_max[sb.issue_rd];
    ready   = !sb.flush && !rs_busy && !(sb.issue_use_rt && rt_busy) && !rd_full;
    accepted = sb.issue_valid && ready;
  end

  assign sb.issue_ready = ready;

  // Per-register increment on accepted write issue, decrement on release.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      inc[i] = accepted && sb.issue_wr && (sb.issue_rd == reg_num_t'(i));
      dec[i] = sb.wb_valid && (sb.wb_num == reg_num_t'(i)) && !is_zero[i];
    end
  end

  // Status next-state: busy mask tracks post-update counts, stall counter
  // saturates, err latches underflow attempts outside a flush.
  always_comb begin
    busy_mask_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_mask_d[i] = (cnt_nxt[i] != '0);
    end
    stall_cnt_d = stall_cnt_q;
    if (sb.issue_valid && !ready && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    err_d = err_q;
    if (sb.wb_valid && (sb.wb_num != REG_ZERO) && is_zero[sb.wb_num] && !sb.flush) begin
      err_d = 1'b1;
    end
  end

  // Status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_mask_q <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_mask_q <= busy_mask_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign busy_mask = busy_mask_q;
  assign stall_cnt = stall_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: stimulus pushes expected responses
// from a count-per-register model; a negedge monitor pops and compares.
module tb_reg_scoreboard;
  import cpu_pkg::*;

  localparam int CNT_W   = 2;
  localparam int STALL_W = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int STALL_MAX = (1 << STALL_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_REGS-1:0] busy_mask;
  logic [STALL_W-1:0]  stall_cnt;
  logic                err;

  reg_scoreboard_if sb_if ();

  reg_scoreboard #(.CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sb        (sb_if),
    .busy_mask (busy_mask),
    .stall_cnt (stall_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ready;
    logic [31:0] busy;
    int          stall;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: pending write count per register.
  int m_pend [NUM_REGS];
  int m_stall;
  bit m_err;

  function automatic int eff(int r, bit wbv, int wbn);
    if (wbv && wbn == r && m_pend[r] > 0) return m_pend[r] - 1;
    return m_pend[r];
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int i = 0; i < NUM_REGS; i++) b[i] = (m_pend[i] > 0);
    return b;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NUM_REGS; i++) m_pend[i] = 0;
    m_stall = 0;
    m_err   = 1'b0;
  endfunction

  task automatic cyc(bit v, int rs, int rt, bit urt, bit wr, int rd,
                     bit wbv, int wbn, bit fl, bit r);
    exp_t e;
    bit rdy;
    @(posedge clk);
    #1;
    rst                = r;
    sb_if.issue_valid  = v;
    sb_if.issue_rs     = reg_num_t'(rs);
    sb_if.issue_rt     = reg_num_t'(rt);
    sb_if.issue_use_rt = urt;
    sb_if.issue_wr     = wr;
    sb_if.issue_rd     = reg_num_t'(rd);
    sb_if.wb_valid     = wbv;
    sb_if.wb_num       = reg_num_t'(wbn);
    sb_if.flush        = fl;

    rdy = 1'b1;
    if (fl) rdy = 1'b0;
    if (rs != 0 && eff(rs, wbv, wbn) > 0) rdy = 1'b0;
    if (urt && rt != 0 && eff(rt, wbv, wbn) > 0) rdy = 1'b0;
    if (wr && rd != 0 && m_pend[rd] == CNT_MAX) rdy = 1'b0;

    e.ready = rdy;
    e.busy  = m_busy();
    e.stall = m_stall;
    e.err   = m_err;
    exp_q.push_back(e);

    if (r) begin
      m_reset();
    end else begin
      if (v && !rdy && m_stall < STALL_MAX) m_stall++;
      if (fl) begin
        for (int i = 0; i < NUM_REGS; i++) m_pend[i] = 0;
      end else begin
        bit hit;
        hit = wbv && wbn != 0 && m_pend[wbn] > 0;
        if (wbv && wbn != 0 && m_pend[wbn] == 0) m_err = 1'b1;
        if (v && rdy && wr && rd != 0) m_pend[rd]++;
        if (hit) m_pend[wbn]--;
      end
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue(int rs, int rt, bit urt, bit wr, int rd);
    cyc(1, rs, rt, urt, wr, rd, 0, 0, 0, 0);
  endtask

  task automatic wb(int n);
    cyc(0, 0, 0, 0, 0, 0, 1, n, 0, 0);
  endtask

  // Monitor: compare DUT against the oldest expected response.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks += 4;
      if (sb_if.issue_ready !== e.ready) begin
        n_fail++;
        $display("FAIL issue_ready t=%0t: got %b expected %b", $time, sb_if.issue_ready, e.ready);
      end
      if (busy_mask !== e.busy) begin
        n_fail++;
        $display("FAIL busy_mask t=%0t: got %h expected %h", $time, busy_mask, e.busy);
      end
      if (stall_cnt !== STALL_W'(e.stall)) begin
        n_fail++;
        $display("FAIL stall_cnt t=%0t: got %0d expected %0d", $time, stall_cnt, e.stall);
      end
      if (err !== e.err) begin
        n_fail++;
        $display("FAIL err t=%0t: got %b expected %b", $time, err, e.err);
      end
    end
  end

  initial begin
    rst                = 1'b1;
    sb_if.issue_valid  = 1'b0;
    sb_if.issue_rs     = '0;
    sb_if.issue_rt     = '0;
    sb_if.issue_use_rt = 1'b0;
    sb_if.issue_wr     = 1'b0;
    sb_if.issue_rd     = '0;
    sb_if.wb_valid     = 1'b0;
    sb_if.wb_num       = '0;
    sb_if.flush        = 1'b0;
    m_reset();
    @(posedge clk);

    // Basic hazard: write r5, then a reader of r5 stalls.
    cyc(1, 1, 2, 1, 1, 5, 0, 0, 0, 0);
    issue(5, 0, 0, 0, 0);
    issue(5, 0, 0, 0, 0);
    issue(5, 0, 0, 0, 0);
    // Same-cycle writeback bypass.
    cyc(1, 5, 0, 0, 0, 0, 1, 5, 0, 0);
    idle();

    // Counter saturation on r7.
    issue(0, 0, 0, 1, 7);
    issue(0, 0, 0, 1, 7);
    issue(0, 0, 0, 1, 7);
    issue(0, 0, 0, 1, 7);
    cyc(1, 0, 0, 0, 1, 7, 1, 7, 0, 0);
    wb(7);
    cyc(1, 0, 0, 0, 1, 7, 1, 7, 0, 0);
    wb(7);
    wb(7);
    idle();

    // Register 0 is never tracked.
    issue(0, 0, 1, 1, 0);
    wb(0);
    idle();

    // Underflow, then flush with several registers busy.
    wb(9);
    issue(0, 0, 0, 1, 3);
    issue(0, 0, 0, 1, 4);
    issue(0, 0, 0, 1, 6);
    cyc(1, 0, 0, 0, 1, 8, 1, 3, 1, 0);
    idle();
    wb(4);
    idle();

    // Stall counter saturation.
    issue(0, 0, 0, 1, 10);
    for (int i = 0; i < 20; i++) issue(10, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    idle();

    // Randomized traffic on a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      bit wbv;
      wbv = ($urandom_range(0, 1) == 1);
      cyc(($urandom_range(0, 3) != 0),
          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 7),
          wbv, $urandom_range(0, 7),
          ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 99) == 0));
    end
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
